// File: rtl/hazard_ctrl_v2_if.sv
// Bus handshake bundle between the fetch/data SRAM-style buses and the
// hazard controller. The bus side drives every signal; the controller only
// observes them.
interface hazard_ctrl_v2_if;
  logic inst_req;
  logic inst_data_ok;
  logic data_req;
  logic data_data_ok;

  modport master (
    output inst_req,
    output inst_data_ok,
    output data_req,
    output data_data_ok
  );

  modport slave (
    input inst_req,
    input inst_data_ok,
    input data_req,
    input data_data_ok
  );
endinterface

// File: rtl/hazard_ctrl_v2.sv
// Pipeline hazard/stall controller for the 5-stage core: forwarding selects,
// load-use and branch stalls, divider busy counter, outstanding-bus tracker
// and deferred exception flush.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no fetch/data transaction outstanding
// WAIT  | at least one transaction outstanding; pipeline held until done
module hazard_ctrl_v2 #(
  parameter int RW      = 5,
  parameter int DIV_LAT = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [RW-1:0] rsD,
  input  logic [RW-1:0] rtD,
  input  logic          branchD,
  input  logic [RW-1:0] rsE,
  input  logic [RW-1:0] rtE,
  input  logic [RW-1:0] writeregE,
  input  logic          regwriteE,
  input  logic          memtoregE,
  input  logic          div_startE,
  input  logic [RW-1:0] writeregM,
  input  logic [RW-1:0] writeregW,
  input  logic          regwriteM,
  input  logic          memtoregM,
  input  logic          regwriteW,
  input  logic [31:0]   excepttypeM,
  hazard_ctrl_v2_if.slave bus,
  output logic          forwardaD,
  output logic          forwardbD,
  output logic [1:0]    forwardaE,
  output logic [1:0]    forwardbE,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          stallM,
  output logic          stallW,
  output logic          flushF,
  output logic          flushD,
  output logic          flushE,
  output logic          flushM,
  output logic          flushW,
  output logic          div_busyE,
  output logic          div_doneE,
  output logic          flushexceptM
);

  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state, state_next;
  logic          inst_pend, data_pend;
  logic          inst_pend_next, data_pend_next;
  logic          exc_pend, exc_pend_next;
  logic          memstall;
  logic          all_ok;
  logic          except_req;
  logic          lwstall, branchstall;
  logic [CW-1:0] cnt;

  // Bus tracker state, pending flags and deferred-exception flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      inst_pend <= 1'b0;
      data_pend <= 1'b0;
      exc_pend  <= 1'b0;
    end else begin
      state     <= state_next;
      inst_pend <= inst_pend_next;
      data_pend <= data_pend_next;
      exc_pend  <= exc_pend_next;
    end
  end

  // Next-state, pending tracking, memstall and exception deferral
  always_comb begin
    state_next = state;
    // A req in the same cycle as data_ok starts a new transaction, so the
    // pending flag stays set while the older one completes.
    inst_pend_next = bus.inst_req | (inst_pend & ~bus.inst_data_ok);
    data_pend_next = bus.data_req | (data_pend & ~bus.data_data_ok);
    all_ok = (~inst_pend | bus.inst_data_ok) & (~data_pend | bus.data_data_ok);
    memstall = (state == WAIT) & ~all_ok;
    case (state)
      IDLE: if (bus.inst_req | bus.data_req) state_next = WAIT;
      WAIT: if (~(inst_pend_next | data_pend_next)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    except_req    = |excepttypeM;
    flushexceptM  = ~memstall & (except_req | exc_pend);
    exc_pend_next = memstall & (except_req | exc_pend);
  end

  // Divider busy counter; an exception flush aborts it without a done pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt       <= '0;
      div_busyE <= 1'b0;
    end else if (flushexceptM) begin
      cnt       <= '0;
      div_busyE <= 1'b0;
    end else if (div_busyE) begin
      if (cnt == '0) div_busyE <= 1'b0;
      else           cnt       <= cnt - CW'(1);
    end else if (div_startE) begin
      cnt       <= CW'(DIV_LAT - 1);
      div_busyE <= 1'b1;
    end
  end

  assign div_doneE = div_busyE & (cnt == '0) & ~flushexceptM;

  // Forwarding selects; register 0 is hardwired and never forwarded
  always_comb begin
    forwardaD = (rsD != '0) & (rsD == writeregM) & regwriteM;
    forwardbD = (rtD != '0) & (rtD == writeregM) & regwriteM;
    forwardaE = 2'b00;
    forwardbE = 2'b00;
    if ((rsE != '0) & (rsE == writeregM) & regwriteM)      forwardaE = 2'b10;
    else if ((rsE != '0) & (rsE == writeregW) & regwriteW) forwardaE = 2'b01;
    if ((rtE != '0) & (rtE == writeregM) & regwriteM)      forwardbE = 2'b10;
    else if ((rtE != '0) & (rtE == writeregW) & regwriteW) forwardbE = 2'b01;
  end

  // Stage stalls and flushes
  always_comb begin
    lwstall     = memtoregE & ((rtE == rsD) | (rtE == rtD));
    branchstall = branchD &
                  ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                   (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
    stallF = lwstall | branchstall | div_busyE | memstall;
    stallD = stallF;
    stallE = div_busyE | memstall;
    stallM = memstall;
    stallW = memstall;
    flushF = flushexceptM;
    flushD = flushexceptM;
    flushW = flushexceptM;
    flushE = (stallD & ~stallE) | flushexceptM;
    flushM = flushexceptM | (stallE & ~stallM);
  end

endmodule

// File: doc/hazard_ctrl_v2.md
# hazard_ctrl_v2

Parametrised pipeline hazard and stall controller for the 5-stage core with SRAM-style variable-latency instruction and data buses. It sits beside the datapath and drives all stage stall/flush and forwarding selects. It also owns an internal divider busy counter and a bus-wait tracker that holds the pipeline until every outstanding fetch/data transaction completes. Exceptions raised while a bus transaction is outstanding are deferred until that transaction returns.

## Interface
Parameters:
- RW, 5, register-index width
- DIV_LAT, 32, divider latency in cycles (≥2)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  synchronous, active-low reset
- rsD, rtD  in  RW  decode source regs
- branchD  in  1  branch/jump-register in D
- rsE, rtE, writeregE  in  RW  execute regs
- regwriteE, memtoregE  in  1  E write/load flags
- div_startE  in  1  divide instruction enters E
- writeregM, writeregW  in  RW  M/W destinations
- regwriteM, memtoregM, regwriteW  in  1  M/W flags
- excepttypeM  in  32  nonzero = exception in M
- inst_req  in  1  fetch transaction issued this cycle
- inst_data_ok  in  1  fetch data returned (1-cycle pulse)
- data_req  in  1  M-stage load/store issued this cycle
- data_data_ok  in  1  data returned/store acked (pulse)
- forwardaD, forwardbD  out  1  D-stage forward from M
- forwardaE, forwardbE  out  2  00 regfile, 10 from M, 01 from W
- stallF, stallD, stallE, stallM, stallW  out  1  stage hold
- flushF, flushD, flushE, flushM, flushW  out  1  stage clear
- div_busyE  out  1  divider counting
- div_doneE  out  1  1-cycle pulse, quotient valid
- flushexceptM  out  1  exception flush actually taken

## Operation
- Forwarding: index 0 never forwarded; M priority over W. forwardaD/bD = src≠0 & src==writeregM & regwriteM.
- lwstall = memtoregE & (rtE==rsD | rtE==rtD). branchstall = branchD & ((regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})).
- Divider counter: div_startE while idle loads cnt=DIV_LAT-1, div_busyE=1; decrement each cycle; at cnt==0 div_busyE drops, div_doneE pulses. div_startE while busy ignored. During a bus wait the counter keeps running.
- Bus tracker FSM, states: IDLE, WAIT. Flags inst_pend, data_pend set on req, cleared on matching data_ok. Same-cycle req and data_ok of same channel: data_ok completes the earlier transaction, pend stays 1. busW = inst_pend|data_pend (registered-state based) ; IDLE→WAIT when any req issued; WAIT→IDLE in cycle after last pend clears.
- Stalls: memstall = state==WAIT & ~(all pending ok this cycle). stallF=stallD = lwstall|branchstall|div_busyE|memstall; stallE = div_busyE|memstall; stallM=stallW = memstall.
- Exceptions: except_req = |excepttypeM. If memstall=0, flushexceptM=except_req. If memstall=1, latch exc_pend; flushexceptM asserts in first cycle memstall drops, then exc_pend clears. New except_req while exc_pend is absorbed.
- Flushes: flushF=flushD=flushW=flushexceptM; flushE = (stallD & ~stallE) | flushexceptM; flushM = flushexceptM | (stallE & ~stallM). flushexceptM aborts the divider (cnt, busy cleared, no div_doneE).

## Timing
- Forwarding, lw/branch stalls: combinational, same cycle.
- Divider: div_startE at edge N → div_busyE high N+1..N+DIV_LAT-1... precisely DIV_LAT cycles, div_doneE in the last busy cycle.
- data_ok earliest one cycle after req; memstall releases in the data_ok cycle (combinational on data_ok).
- Reset (resetn=0 at edge): state IDLE, pend flags, exc_pend, cnt, div_busyE, div_doneE = 0; all stalls/flushes 0, forwards 00 (given zero inputs). Reset mid-wait abandons tracking; late data_ok after reset is ignored.

## Test plan
- rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 → forwardaE=10; rsE=0 same → 00.
- memtoregE=1, rtE=5, rsD=5 → stallF=stallD=flushE=1, stallE=0 for one cycle.
- DIV_LAT=4, div_startE pulse → div_busyE 4 cycles, stallE high, div_doneE on 4th; second start during busy ignored.
- inst_req and data_req same cycle, data_data_ok +2, inst_data_ok +5 → all stalls high until cycle +5, drop that cycle.
- excepttypeM=0x20 while data_pend, data_ok +3 → flushexceptM=0 until cycle +3, then one-cycle flush of all stages.
- resetn=0 during WAIT with divider busy → next cycle all outputs 0, stray data_ok causes no stall.
